ex_div: RTL
===========

# ex_div

Iterative 32-bit radix-2 restoring divider for the EX stage of the five-stage pipeline. It serves DIV/DIVU: it takes operands from EX decode, holds the pipeline via a stall request, and returns {remainder, quotient}. EX then writes the result to HI/LO and forwards the instruction to MEM on the EX-to-MEM bus.

## Interface

Parameters: none; all widths are fixed.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  reset; synchronous, active-high.
- start_i  input  1  a DIV/DIVU instruction is in EX and requests a division.
- signed_i  input  1  1 = DIV (signed), 0 = DIVU (unsigned); sampled with start_i.
- dividend_i  input  32  rs operand; sampled with start_i.
- divisor_i  input  32  rt operand; sampled with start_i.
- annul_i  input  1  flush or cancel; aborts any division in progress.
- result_o  output  64  {remainder[63:32] → HI, quotient[31:0] → LO}; valid while ready_o=1.
- ready_o  output  1  result valid (state END).
- stallreq_o  output  1  stall request to the stall controller; equals start_i & ~ready_o.

## Operation

Four states: FREE, ZERO, ON, END.

Operand capture (FREE, on the edge where start_i=1 and annul_i=0):
- Latch operand magnitudes: |dividend| and |divisor| when signed_i=1, raw values otherwise.
- Record neg_q = signed & (dividend[31] ^ divisor[31]) & (divisor≠0).
- Record neg_r = signed & dividend[31].
- Clear the 6-bit counter cnt and the 65-bit working register {rem[32:0], quo[31:0]}.

FREE transitions:
- divisor_i = 0 → ZERO (when DIV_FAST_ZERO_EN is defined).
- Otherwise → ON.

ON, one iteration per cycle:
- Shift {rem, quo} left by 1.
- Trial subtraction: diff = rem[32:0] − {1'b0, divisor}, 33 bits.
- If diff is non-negative: rem ← diff and quo[0] ← 1. Otherwise quo[0] ← 0.
- cnt increments each cycle. The iteration with cnt = 31 is the last one; on that edge the state moves to END.
- On entry to END: result_o ← {neg_r ? −rem[31:0] : rem[31:0], neg_q ? −quo : quo}, two's complement, truncated to 32 bits.

ZERO:
- Next edge → END with result_o = 64'h0.

END:
- ready_o = 1.
- Stays in END while start_i = 1. This is the EX hold cycle: stallreq_o drops, so the pipeline advances.
- → FREE on the first cycle with start_i = 0.

Annul and reset:
- annul_i = 1 in any state → FREE on the next edge. The result is discarded and ready_o is never asserted for that division.
- A start_i presented in the same cycle as annul_i is ignored.
- rst has priority over everything: state = FREE, cnt = 0, result_o = 0, ready_o = 0, stallreq_o = start_i. Reset in the middle of ON abandons the operation.

Edge case: the signed 0x80000000 operand. Its magnitude is held as an unsigned 32-bit 0x80000000, so no overflow occurs internally. The quotient negation truncates to 32 bits.

## Timing

- Cycle 0: start_i high in FREE.
- Cycles 1–32: ON, with stallreq_o = 1 throughout.
- Cycle 33: END with ready_o = 1. result_o is registered and stable. stallreq_o = 0, and EX launches the instruction to MEM on the edge ending cycle 33.
- Division by zero with the macro defined: ZERO in cycle 1, END in cycle 2.
- stallreq_o is combinational from start_i and state. There is no path from operand data to stallreq_o.
- Back-to-back divides: the second start_i is accepted only after one FREE cycle, because start_i must drop for END to exit.

## Configuration

Macro: `DIV_FAST_ZERO_EN`.
- Defined: a zero divisor takes the ZERO path. Latency is 2 cycles and result_o = 0.
- Undefined: the ZERO state is not built and a zero divisor runs the full 32 iterations. The result is quo = 0xFFFFFFFF and rem = |dividend|, with the neg_r sign correction applied. neg_q = 0 in this case.

## Test plan

1. Unsigned divide: DIVU 100 / 7, start held high → stallreq_o high for cycles 0–32; ready_o in cycle 33 with result_o = {32'd2, 32'd14}.
2. Signed divide: DIV −7 / 2 → result_o = {32'hFFFFFFFF, 32'hFFFFFFFD}. Also DIV 0x80000000 / 0xFFFFFFFF → {32'h0, 32'h80000000}.
3. Annul mid-operation: DIVU 0xFFFFFFFF / 3 with annul_i pulsed in cycle 10 → FREE in cycle 11 and ready_o never asserted. A new start in cycle 12 for 9 / 3 → {0, 3} in cycle 45.
4. Divide by zero, `DIV_FAST_ZERO_EN` defined: DIVU 5 / 0 → ready_o in cycle 2 with result_o = 0.
5. Divide by zero, macro undefined: DIVU 5 / 0 → ready_o in cycle 33 with result_o = {32'd5, 32'hFFFFFFFF}.
6. Reset and back-to-back: rst asserted in cycle 20 of a division → FREE, result_o = 0, ready_o = 0 the next cycle. Separately, start_i held through END → END persists; after start_i drops, FREE follows and the next divide is accepted.

Source files
------------

// File: rtl/ex_div.sv
// ex_div: iterative 32-bit radix-2 restoring divider for DIV/DIVU in EX, returning {remainder, quotient}.
// Define DIV_FAST_ZERO_EN to short-cut a zero divisor through the ZERO state (result 0, 2-cycle latency).
module ex_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        stallreq_o
);
    typedef enum logic [1:0] {FREE, ZERO, ON, END} state_e;
    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic        negq_q, negq_d, negr_q, negr_d;
    logic [63:0] result_q, result_d;
    logic [32:0] diff;
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        result_d = result_q;
        // rem never reaches the divisor, so the shifted partial remainder fits in 33 bits
        diff     = {rem_q, quo_q[31]} - {1'b0, dvs_q};
        case (state_q)
            FREE: if (start_i && !annul_i) begin
                dvs_d  = (signed_i && divisor_i[31]) ? -divisor_i : divisor_i;
                quo_d  = (signed_i && dividend_i[31]) ? -dividend_i : dividend_i;
                rem_d  = '0;
                cnt_d  = '0;
                negq_d = signed_i & (dividend_i[31] ^ divisor_i[31]) & (|divisor_i);
                negr_d = signed_i & dividend_i[31];
`ifdef DIV_FAST_ZERO_EN
                state_d = (divisor_i == 32'd0) ? ZERO : ON;
`else
                state_d = ON;
`endif
            end
`ifdef DIV_FAST_ZERO_EN
            ZERO: begin
                state_d  = END;
                result_d = '0;
            end
`endif
            ON: begin
                rem_d = diff[32] ? {rem_q[30:0], quo_q[31]} : diff[31:0];
                quo_d = {quo_q[30:0], ~diff[32]};
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d  = END;
                    result_d = {negr_q ? -rem_d : rem_d, negq_q ? -quo_d : quo_d};
                end
            end
            END:     state_d = start_i ? END : FREE;
            default: state_d = FREE;
        endcase
        if (annul_i) state_d = FREE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FREE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            result_q <= result_d;
        end
    end
    assign result_o   = result_q;
    assign ready_o    = (state_q == END);
    assign stallreq_o = start_i & ~ready_o;
endmodule
